hex_scan_display: RTL and testbench
===================================

Name: hex_scan_display

Overview:
- Multiplexed N-digit hexadecimal seven-segment display driver for the lab boards.
- Successor to the single-digit combinational hex-to-segment decoder:
  - generalised to DIGITS digits sharing one segment bus;
  - adds a scan prescaler, per-digit blanking, decimal points, leading-zero suppression, tear-free frame-synchronous value update and anti-ghosting dead time.
- Sits between datapath result registers and the board's segment/anode pins.

Parameters:
- DIGITS, 4: number of multiplexed digits (1..8).
- CLK_DIV, 50000: clocks per digit slot (≥ DEAD_CYCLES+2).
- DEAD_CYCLES, 2: clocks at the start of each slot with all anodes inactive.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp pins active-low.
- AN_ACTIVE_LOW, 1: 1 = anode pins active-low.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous active-low reset.
- value, in, 4*DIGITS: hex nibbles; digit i = value[4i+3:4i]; digit 0 rightmost.
- dp_in, in, DIGITS: decimal point request per digit.
- blank, in, DIGITS: force digit dark.
- lz_suppress, in, 1: enable leading-zero suppression.
- load, in, 1: strobe; captures value/dp_in/blank into the shadow register.
- seg, out, 7: segments; seg[0]=a … seg[6]=g.
- dp, out, 1: decimal point segment.
- an, out, DIGITS: digit enables.
- frame_done, out, 1: one-clock pulse at each frame wrap.

Behaviour:
- One clock domain (clk). Synchronous, active-low reset (rst_n).
- Reset values:
  - prescaler cnt=0, digit index idx=0;
  - shadow and display registers = 0;
  - frame_done=0;
  - an all inactive; seg and dp all inactive (polarity per parameters).
- Prescaler:
  - cnt counts 0..CLK_DIV-1; tick when cnt==CLK_DIV-1.
  - On tick: cnt←0 and idx←idx+1, or idx←0 when idx==DIGITS-1 (wrap).
- Shadow register:
  - load=1 captures value/dp_in/blank and sets pending=1.
  - A second load before the frame wrap overwrites the shadow; last load wins.
- Frame update, on a wrap tick:
  - display ← shadow if pending; pending←0.
  - If load coincides with the wrap tick, display takes the live inputs directly, and pending stays 0.
  - The display register never changes mid-frame.
- frame_done: registered and high for exactly one clock, the cycle after the wrap tick (when idx reads 0).
- Leading-zero suppression, evaluated on the display register:
  - With lz_suppress=1, digit i is dark if every nibble from DIGITS-1 down to i is 0.
  - Digit 0 is never suppressed, so 0 shows as a single "0".
  - A dp on a suppressed digit still lights (dp independent of suppression).
- blank[i]=1 darkens both the segments and the dp of digit i.
- Outputs are registered, 1-clock latency from (idx, cnt) to pins:
  - cnt < DEAD_CYCLES: all anodes inactive, seg and dp inactive.
  - Otherwise: an[idx] active, all other anodes inactive; seg=decode(display nibble idx), or all inactive if the digit is dark.
- Decode table, active-high {g..a}:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Result is inverted when SEG_ACTIVE_LOW=1.
- Reset mid-frame: every register returns to its reset value on the next clock edge; scanning restarts at digit 0 with a dead period. Pending load is discarded.
- DIGITS=1: idx is constant 0; every tick is a wrap; frame_done pulses once per CLK_DIV clocks.
- Index width is clog2(DIGITS), minimum 1. The index compare handles non-power-of-two DIGITS, so idx never exceeds DIGITS-1.

Decomposition:
- Shared package hex_disp_pkg:
  - the 16-entry segment table constant;
  - segment bit-index constants SEG_A..SEG_G;
  - localparam helper for index width.
- Sub-module hex7_decode: combinational 4-bit → 7-bit active-high decoder using the package table. Polarity inversion is done in the top level.

Test Plan (DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2, active-low):
- Reset: hold rst_n=0 for 3 clocks → an=4'hF, seg=7'h7F, dp=1, frame_done=0. Release → first an=4'hE appears 3 clocks later (cycle cnt=2 plus 1-clock latency).
- Scan: load value=16'h1A3F, lz_suppress=0, then wait one frame wrap. Next frame shows, in order: an=E seg=~71, an=D seg=~4F, an=B seg=~77, an=7 seg=~06. Each enable lasts 6 clocks, separated by 2 dark clocks; frame_done pulses every 32 clocks.
- Tear-free: pulse load with 16'h0000 mid-frame → remaining digits of the current frame keep the old values; new values appear only after frame_done.
- LZ suppression: value=16'h0070, lz_suppress=1 → digits 3 and 2 dark (an stays F in their slots), digit 1 shows 7, digit 0 shows 0. value=0 → only digit 0 lit, showing "0".
- Blank/dp: dp_in=4'b0100, blank=4'b0001, value=16'h0000, lz_suppress=1 → digit 2 slot shows dp=0 with seg=7F; digit 0 is dark including dp.
- Load coincident with wrap tick, and reset asserted mid-slot → display takes the live value in the next frame; mid-slot reset forces outputs inactive on the next clock edge.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared constants for the multiplexed hex display: segment table, bit indices
// and the index-width helper.
package hex_disp_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-high {g..a}, entry 15 first so SEG_TABLE[n] is the pattern for nibble n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex7_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  logic [6:0] row;

  always_comb begin
    row          = SEG_TABLE[nib_i];
    seg_o        = '0;
    seg_o[SEG_A] = row[SEG_A];
    seg_o[SEG_B] = row[SEG_B];
    seg_o[SEG_C] = row[SEG_C];
    seg_o[SEG_D] = row[SEG_D];
    seg_o[SEG_E] = row[SEG_E];
    seg_o[SEG_F] = row[SEG_F];
    seg_o[SEG_G] = row[SEG_G];
  end

endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed N-digit hex display driver with frame-synchronous update,
// leading-zero suppression, blanking, decimal points and anode dead time.
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = idx_width(DIGITS);
  localparam int unsigned CNT_W = idx_width(CLK_DIV);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LIVE = CNT_W'(DEAD_CYCLES);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [4*DIGITS-1:0] sh_val_q, disp_val_q;
  logic [DIGITS-1:0]   sh_dp_q, sh_bl_q, disp_dp_q, disp_bl_q;
  logic                pend_q;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q;

  logic                tick, wrap, live, zero_run;
  logic [DIGITS-1:0]   lz_dark;
  logic [3:0]          nib;
  logic                cur_dp, cur_bl, cur_lz, seg_on, dp_on;
  logic [6:0]          dec_seg;

  assign tick = (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);
  assign live = (cnt_q >= CNT_LIVE);

  hex7_decode u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    zero_run = 1'b1;
    lz_dark  = '0;
    // Walk from the most significant digit down; digit 0 is never suppressed
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_run = zero_run && (disp_val_q[4*(DIGITS-1-k) +: 4] == 4'h0);
      if (k != DIGITS - 1)
        lz_dark[DIGITS-1-k] = lz_suppress && zero_run;
    end

    nib    = '0;
    cur_dp = 1'b0;
    cur_bl = 1'b0;
    cur_lz = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib    = disp_val_q[4*k +: 4];
        cur_dp = disp_dp_q[k];
        cur_bl = disp_bl_q[k];
        cur_lz = lz_dark[k];
      end
    end

    seg_on = !cur_bl && !cur_lz;
    dp_on  = !cur_bl && cur_dp;
    seg_d  = (live && seg_on) ? (dec_seg ^ SEG_OFF) : SEG_OFF;
    dp_d   = (live && dp_on) ? ~SEG_ACTIVE_LOW : SEG_ACTIVE_LOW;
    an_d   = AN_OFF;
    // Anode only drives when something in the slot is lit
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (live && (seg_on || dp_on) && (idx_q == IDX_W'(k)))
        an_d[k] = ~AN_ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      sh_bl_q    <= '0;
      pend_q     <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_bl_q  <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= SEG_ACTIVE_LOW;
      an_q       <= AN_OFF;
      fd_q       <= 1'b0;
    end else begin
      fd_q <= wrap;
      if (tick) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (load) begin
        sh_val_q <= value;
        sh_dp_q  <= dp_in;
        sh_bl_q  <= blank;
      end

      // A load landing on the wrap tick bypasses the shadow entirely
      if (wrap) begin
        pend_q <= 1'b0;
        if (load) begin
          disp_val_q <= value;
          disp_dp_q  <= dp_in;
          disp_bl_q  <= blank;
        end else if (pend_q) begin
          disp_val_q <= sh_val_q;
          disp_dp_q  <= sh_dp_q;
          disp_bl_q  <= sh_bl_q;
        end
      end else if (load) begin
        pend_q <= 1'b1;
      end

      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed self-checking bench for hex_scan_display (4 digits, 8-clock slots).
module tb_hex_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in, blank;
  logic        lz_suppress, load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  hex_scan_display #(
    .DIGITS         (4),
    .CLK_DIV        (8),
    .DEAD_CYCLES    (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp_in       (dp_in),
    .blank       (blank),
    .lz_suppress (lz_suppress),
    .load        (load),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_fdwait"}, 32'(seen), 32'd1);
  endtask

  // Starts at the negedge where frame_done is high; ends at the next such negedge.
  // Optionally loads new values mid-frame (slot 1) and/or on the wrap tick.
  task automatic check_frame(input string tag, input logic [15:0] ean,
                             input logic [27:0] eseg, input logic [3:0] edp,
                             input bit do_load, input logic [15:0] nval,
                             input logic [3:0] ndp, input logic [3:0] nbl,
                             input bit wload, input logic [15:0] wval);
    for (int d = 0; d < 4; d++) begin
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        load = 1'b0;
        if (d == 0 && n == 1) chk({tag, "_fdlow"}, 32'(frame_done), 32'd0);
        if (n == 2) chk($sformatf("%s_dead%0d", tag, d), 32'(an), 32'hF);
        if (n == 5) begin
          chk($sformatf("%s_an%0d", tag, d), 32'(an), 32'(ean[4*d +: 4]));
          chk($sformatf("%s_seg%0d", tag, d), 32'(seg), 32'(eseg[7*d +: 7]));
          chk($sformatf("%s_dp%0d", tag, d), 32'(dp), 32'(edp[d]));
          if (d == 1 && do_load) begin
            value = nval; dp_in = ndp; blank = nbl; load = 1'b1;
          end
        end
        if (d == 3 && n == 7 && wload) begin
          value = wval; dp_in = 4'h0; blank = 4'h0; load = 1'b1;
        end
        if (d == 3 && n == 8) chk({tag, "_fd"}, 32'(frame_done), 32'd1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; value = '0; dp_in = '0; blank = '0; lz_suppress = 1'b0; load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_dead", 32'(an), 32'hF);
    @(negedge clk);
    chk("rel_an", 32'(an), 32'hE);
    chk("rel_seg", 32'(seg), 32'h40);
    value = 16'h1A3F; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd("f0");

    check_frame("f1", 16'h7BDE, {7'h79, 7'h08, 7'h30, 7'h0E}, 4'hF,
                1'b1, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0);
    check_frame("f2", 16'h7BDE, {4{7'h40}}, 4'hF,
                1'b1, 16'h0070, 4'h0, 4'h0, 1'b0, 16'h0);
    lz_suppress = 1'b1;
    check_frame("f3", 16'hFFDE, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF,
                1'b1, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0);
    check_frame("f4", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF,
                1'b1, 16'h0000, 4'b0100, 4'b0001, 1'b0, 16'h0);
    check_frame("f5", 16'hFBFF, {4{7'h7F}}, 4'b1011,
                1'b1, 16'h1111, 4'h0, 4'h0, 1'b0, 16'h0);
    lz_suppress = 1'b0;
    check_frame("f6", 16'h7BDE, {4{7'h79}}, 4'hF,
                1'b1, 16'h2222, 4'h0, 4'h0, 1'b1, 16'hBEEF);
    check_frame("f7", 16'h7BDE, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'hF,
                1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 16'h0);

    value = 16'h5555; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_an", 32'(an), 32'hE);
    chk("mid_seg", 32'(seg), 32'h0E);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_an", 32'(an), 32'hF);
    chk("mrst_seg", 32'(seg), 32'h7F);
    chk("mrst_dp", 32'(dp), 32'd1);
    chk("mrst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrel_dead", 32'(an), 32'hF);
    @(negedge clk);
    chk("mrel_an", 32'(an), 32'hE);
    chk("mrel_seg", 32'(seg), 32'h40);
    wait_fd("f8w");
    check_frame("f8", 16'h7BDE, {4{7'h40}}, 4'hF,
                1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
